// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 register-dump slice.
//
// Contents:
//   REG_IDX_W    - width of a register-file index (8 registers).
//   WORD_W       - width of a register-file word.
//   dump_state_t - state encoding of the register dump sequencer.
package slc3_pkg;

  localparam int REG_IDX_W = 3;
  localparam int WORD_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SEND   = 2'd2,
    ST_DONE   = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_dump.sv
// reg_dump: walks register-file indices START_IDX..END_IDX through the SR1
// read port and streams each (index, contents) pair out as a valid/ready beat.
//
// Ports:
//   CLK         clock, all state updates on its rising edge
//   Reset       synchronous, active-high reset
//   Start       one-cycle dump request, only looked at while idle
//   Abort       stops a dump in progress, ignored while idle
//   SR_SEL      register index driven to the register file SR1 select
//   SR_DATA     register file SR1 output (combinational in SR_SEL)
//   Dump_Valid  beat on Dump_Index/Dump_Data is valid
//   Dump_Ready  downstream takes the beat when high with Dump_Valid
//   Dump_Index  register number of the current beat
//   Dump_Data   captured register contents of the current beat
//   Busy        high whenever a dump is in progress (any state but IDLE)
//   Done        one-cycle pulse after the last beat is accepted
//   dbg_state   current sequencer state, for observation only
//
// Handshake: a beat transfers on a rising edge where Dump_Valid and Dump_Ready
// are both high. Once Dump_Valid rises, Dump_Index/Dump_Data hold steady
// until that transfer; Dump_Valid never drops without a transfer except on
// Abort or Reset, which discard the beat.
module reg_dump
  import slc3_pkg::*;
#(
  parameter logic [REG_IDX_W-1:0] START_IDX = 3'd0,
  parameter logic [REG_IDX_W-1:0] END_IDX   = 3'd7
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Abort,
  output logic [REG_IDX_W-1:0] SR_SEL,
  input  logic [WORD_W-1:0]    SR_DATA,
  output logic                 Dump_Valid,
  input  logic                 Dump_Ready,
  output logic [REG_IDX_W-1:0] Dump_Index,
  output logic [WORD_W-1:0]    Dump_Data,
  output logic                 Busy,
  output logic                 Done,
  output dump_state_t          dbg_state
);

  // A reversed range would make the walk run past END_IDX and wrap.
  if (START_IDX > END_IDX) begin : g_bad_range
    $error("reg_dump: START_IDX must not exceed END_IDX");
  end

  dump_state_t          state_q,  state_nxt;
  logic [REG_IDX_W-1:0] idx_q,    idx_nxt;
  logic [REG_IDX_W-1:0] sr_sel_q, sr_sel_nxt;
  logic [REG_IDX_W-1:0] index_q,  index_nxt;
  logic [WORD_W-1:0]    data_q,   data_nxt;

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      sr_sel_q <= '0;
      index_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_nxt;
      idx_q    <= idx_nxt;
      sr_sel_q <= sr_sel_nxt;
      index_q  <= index_nxt;
      data_q   <= data_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt  = state_q;
    idx_nxt    = idx_q;
    sr_sel_nxt = sr_sel_q;
    index_nxt  = index_q;
    data_nxt   = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          idx_nxt    = START_IDX;
          sr_sel_nxt = START_IDX;
          state_nxt  = ST_SELECT;
        end
      end

      // SR_SEL has been stable on idx for this whole cycle, so SR_DATA is
      // settled; snapshot it so later register writes cannot disturb the beat.
      ST_SELECT: begin
        data_nxt  = SR_DATA;
        index_nxt = idx_q;
        state_nxt = ST_SEND;
      end

      ST_SEND: begin
        if (Dump_Ready) begin
          // Compare before incrementing so END_IDX = 7 never wraps to 0.
          if (idx_q == END_IDX) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt    = idx_q + 3'd1;
            sr_sel_nxt = idx_q + 3'd1;
            state_nxt  = ST_SELECT;
          end
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Abort takes priority over an accept in the same cycle: the sequence
    // stops where it is and the pending beat is discarded.
    if (Abort && (state_q != ST_IDLE)) begin
      state_nxt  = ST_IDLE;
      idx_nxt    = idx_q;
      sr_sel_nxt = sr_sel_q;
      index_nxt  = index_q;
      data_nxt   = data_q;
    end
  end

  // Outputs come straight from registers or from the state decode.
  assign SR_SEL     = sr_sel_q;
  assign Dump_Index = index_q;
  assign Dump_Data  = data_q;
  assign Dump_Valid = (state_q == ST_SEND);
  assign Busy       = (state_q != ST_IDLE);
  assign Done       = (state_q == ST_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_reg_dump.sv
// Testbench for reg_dump: a default-range instance (u_dut) exercised with
// directed and randomized dumps, plus a single-register instance (u_one).
module tb_reg_dump;
  import slc3_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic        Reset, Start, Abort, Dump_Ready;
  logic [2:0]  SR_SEL, Dump_Index;
  logic [15:0] SR_DATA, Dump_Data;
  logic        Dump_Valid, Busy, Done;
  dump_state_t dbg_state;

  logic        start1, abort1, ready1;
  logic [2:0]  sr_sel1, index1;
  logic [15:0] sr_data1, data1;
  logic        valid1, busy1, done1;
  dump_state_t dbg1;

  // Register file model: SR1 read is combinational in the select.
  logic [15:0] regs [8];
  assign SR_DATA  = regs[SR_SEL];
  assign sr_data1 = regs[sr_sel1];

  reg_dump u_dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Abort(Abort),
    .SR_SEL(SR_SEL), .SR_DATA(SR_DATA),
    .Dump_Valid(Dump_Valid), .Dump_Ready(Dump_Ready),
    .Dump_Index(Dump_Index), .Dump_Data(Dump_Data),
    .Busy(Busy), .Done(Done), .dbg_state(dbg_state)
  );

  reg_dump #(.START_IDX(3'd7), .END_IDX(3'd7)) u_one (
    .CLK(CLK), .Reset(Reset), .Start(start1), .Abort(abort1),
    .SR_SEL(sr_sel1), .SR_DATA(sr_data1),
    .Dump_Valid(valid1), .Dump_Ready(ready1),
    .Dump_Index(index1), .Dump_Data(data1),
    .Busy(busy1), .Done(done1), .dbg_state(dbg1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Each entry is {index, data} of a beat the reference model predicts.
  logic [18:0] exp_q[$];
  int beats, dones, start_cyc, first_valid_cyc, done_cyc;
  bit          pend;
  logic [18:0] pend_beat;

  // Reference: a dump of lo..hi emits registers in order with the contents
  // held when the dump is requested (tests only write during a dump where
  // the write must be invisible to the pending beat).
  task automatic push_exp(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      logic [2:0] ii;
      ii = i[2:0];
      exp_q.push_back({ii, regs[i]});
    end
  endtask

  always @(negedge CLK) begin
    if (Reset) begin
      pend = 1'b0;
    end else begin
      if (Dump_Valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pend) check("beat_stable", {13'd0, Dump_Index, Dump_Data}, {13'd0, pend_beat});
        if (Dump_Ready && !Abort) begin
          beats++;
          if (exp_q.size() == 0)
            check("beat_unexpected", {13'd0, Dump_Index, Dump_Data}, 32'hFFFF_FFFF);
          else
            check("beat", {13'd0, Dump_Index, Dump_Data}, {13'd0, exp_q.pop_front()});
          pend = 1'b0;
        end else begin
          pend      = 1'b1;
          pend_beat = {Dump_Index, Dump_Data};
        end
      end else begin
        pend = 1'b0;
      end
      if (Done) begin
        dones++;
        done_cyc = cyc;
        check("done_after_last_beat", exp_q.size(), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    Start           = 1'b1;
    start_cyc       = cyc;
    first_valid_cyc = -1;
    done_cyc        = -1;
    tick();
    Start = 1'b0;
  endtask

  // mode 0: Dump_Ready high; 1: stall beat R3 for 5 cycles;
  // 2: overwrite R5 while its beat is pending; 3: random ready + stray Starts.
  task automatic run_dump(input int mode);
    int  hold;
    bit  written;
    hold    = 0;
    written = 1'b0;
    beats   = 0;
    dones   = 0;
    push_exp(0, 7);
    Dump_Ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 400; k++) begin
      if (!Busy) break;
      Dump_Ready = 1'b1;
      Start      = 1'b0;
      case (mode)
        1: if (Dump_Valid && Dump_Index == 3'd3 && hold < 5) begin
             Dump_Ready = 1'b0;
             hold++;
           end
        2: if (Dump_Valid && Dump_Index == 3'd5 && !written) begin
             regs[5] = 16'hBEEF;
             written = 1'b1;
           end
        3: begin
             Dump_Ready = ($urandom_range(0, 3) != 0);
             Start      = ($urandom_range(0, 2) == 0);
           end
        default: ;
      endcase
      tick();
    end
    Start = 1'b0;
    check("dump_timeout", Busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  int saved_dones, t1, v1_cyc, d1_cyc, v1_cnt;
  logic [2:0]  v1_idx;
  logic [15:0] v1_data;

  initial begin
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Dump_Ready = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
    beats = 0; dones = 0; pend = 1'b0;
    start_cyc = 0; first_valid_cyc = -1; done_cyc = -1;
    for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);
    repeat (3) tick();
    @(negedge CLK);
    check("rst_sr_sel", SR_SEL, 3'd0);
    check("rst_valid", Dump_Valid, 1'b0);
    check("rst_index", Dump_Index, 3'd0);
    check("rst_data", Dump_Data, 16'h0000);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    tick();
    Reset = 1'b0;
    tick();

    // Full dump with ready held high: latency and cadence.
    run_dump(0);
    check("full_beats", beats, 8);
    check("full_dones", dones, 1);
    check("first_valid_lat", first_valid_cyc - start_cyc, 2);
    check("done_lat", done_cyc - start_cyc, 17);
    check("idle_lat", cyc - start_cyc, 18);

    // Back-pressure on R3.
    run_dump(1);
    check("stall_beats", beats, 8);
    check("stall_dones", dones, 1);

    // Write to R5 while its beat is pending, then re-dump.
    run_dump(2);
    check("wr_beats", beats, 8);
    run_dump(0);
    check("after_wr_beats", beats, 8);

    // Abort while R2 is offered (accept in the same cycle loses).
    beats = 0; dones = 0;
    push_exp(0, 7);
    Dump_Ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      if (Dump_Valid && Dump_Index == 3'd2) break;
      tick();
    end
    check("abort_reached_r2", {Dump_Valid, Dump_Index}, 4'b1010);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    @(negedge CLK);
    check("abort_busy", Busy, 1'b0);
    check("abort_valid", Dump_Valid, 1'b0);
    exp_q.delete();
    tick();
    tick();
    check("abort_no_done", dones, 0);
    check("abort_beats", beats, 2);
    run_dump(0);
    check("restart_beats", beats, 8);

    // Reset during R6 SELECT, with Start asserted to show Reset wins.
    beats = 0; dones = 0;
    push_exp(0, 7);
    Dump_Ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      if (Dump_Valid && Dump_Index == 3'd5) break;
      tick();
    end
    tick();
    check("r6_select_sel", {Busy, Dump_Valid, SR_SEL}, 5'b10110);
    Reset = 1'b1;
    Start = 1'b1;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    @(negedge CLK);
    check("mid_rst_sr_sel", SR_SEL, 3'd0);
    check("mid_rst_valid", Dump_Valid, 1'b0);
    check("mid_rst_index", Dump_Index, 3'd0);
    check("mid_rst_data", Dump_Data, 16'h0000);
    check("mid_rst_busy", Busy, 1'b0);
    check("mid_rst_done", Done, 1'b0);
    exp_q.delete();
    tick();
    check("mid_rst_no_done", dones, 0);

    // Randomized dumps: random data, random back-pressure, stray Starts.
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom_range(0, 16'hFFFF));
      run_dump(3);
      check("rand_beats", beats, 8);
      check("rand_dones", dones, 1);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Single-register instance (START_IDX = END_IDX = 7).
    regs[7] = 16'($urandom_range(0, 16'hFFFF));
    v1_cyc = -1; d1_cyc = -1; v1_cnt = 0; v1_idx = '0; v1_data = '0;
    start1 = 1'b1;
    t1 = cyc;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (valid1) begin
        v1_cnt++;
        if (v1_cyc < 0) begin
          v1_cyc  = cyc;
          v1_idx  = index1;
          v1_data = data1;
        end
      end
      if (done1 && d1_cyc < 0) d1_cyc = cyc;
    end
    check("one_valid_lat", v1_cyc - t1, 2);
    check("one_index", v1_idx, 3'd7);
    check("one_data", v1_data, regs[7]);
    check("one_beat_count", v1_cnt, 1);
    check("one_done_lat", d1_cyc - t1, 3);
    check("one_idle", busy1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter: START_IDX, default 3'd0, first register index dumped.
REQ-002 Parameter: END_IDX, default 3'd7, last register index dumped; START_IDX <= END_IDX SHALL hold (elaboration-time check).
REQ-003 CLK  input  1  clock; all state SHALL update on posedge CLK.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
REQ-006 Abort  input  1  terminates an in-progress dump; no effect in IDLE.
REQ-007 SR_SEL  output  3  register index driven to the register file SR1 select port.
REQ-008 SR_DATA  input  16  register file SR1_OUT, combinational function of SR_SEL.
REQ-009 Dump_Valid  output  1  Dump_Index/Dump_Data hold a valid beat.
REQ-010 Dump_Ready  input  1  downstream accepts the beat when high together with Dump_Valid.
REQ-011 Dump_Index  output  3  register number of the current beat.
REQ-012 Dump_Data  output  16  captured register contents of the current beat.
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-015 FSM states: IDLE, SELECT, SEND, DONE; all outputs SHALL be registered or decoded from state only.
REQ-016 IDLE: Start=1 -> idx<=START_IDX, SR_SEL<=START_IDX, go SELECT; otherwise stay.
REQ-017 SELECT (exactly 1 cycle): SR_SEL stable = idx; at clock edge Dump_Data<=SR_DATA, Dump_Index<=idx, go SEND.
REQ-018 SEND: Dump_Valid=1; Dump_Index/Dump_Data SHALL stay stable until Dump_Valid&&Dump_Ready.
REQ-019 SEND accept with idx==END_IDX -> DONE; otherwise idx<=idx+1, SR_SEL<=idx+1, go SELECT.
REQ-020 DONE: Done=1 for exactly one cycle, then IDLE; Start in DONE SHALL be ignored.
REQ-021 Latency: Start at cycle t -> first Dump_Valid at t+2; with Dump_Ready held high, one beat every 2 cycles; default full dump: Done at t+17, IDLE at t+18.
REQ-022 Dumped value SHALL be the register contents present during the SELECT cycle; later writes to that register do not alter the pending beat.
REQ-023 Start while Busy SHALL be ignored (no queueing).
REQ-024 Abort=1 in SELECT/SEND/DONE -> IDLE next cycle, Dump_Valid low, no Done pulse; Abort wins over a simultaneous accept.
REQ-025 idx SHALL never wrap: END_IDX=7 terminates without incrementing past 3'd7.
REQ-026 START_IDX==END_IDX SHALL produce exactly one beat then Done.

Reset
REQ-027 Reset=1 at any state SHALL force IDLE next edge and override Start/Abort.
REQ-028 Reset values: SR_SEL=0, Dump_Valid=0, Dump_Index=0, Dump_Data=16'h0000, Busy=0, Done=0, idx=0.
REQ-029 Reset mid-dump SHALL drop the pending beat with no Done pulse.

Structure
REQ-030 Shared package slc3_pkg SHALL hold the 4-state enum type dump_state_t and constants REG_IDX_W=3, WORD_W=16.
REQ-031 Single module, no sub-modules; SR_SEL connects directly to the existing register file SR1 select, leaving SR2 free for the datapath.

Verification
REQ-032 Registers R0..R7 preloaded 16'h1000+n, Dump_Ready=1, Start pulse -> 8 beats (n, 16'h1000+n) in order, Done at t+17.
REQ-033 Dump_Ready low 5 cycles on beat R3 -> Dump_Valid held, Index=3, Data=16'h1003 stable throughout; R4 follows after release.
REQ-034 Write R5<=16'hBEEF during R5 SEND cycle -> beat shows old value 16'h1005; subsequent dump shows 16'hBEEF.
REQ-035 Abort during R2 SEND -> Busy low next cycle, no Done; new Start restarts from R0.
REQ-036 Reset asserted during R6 SELECT -> all outputs at reset values next cycle; Start during Busy ignored (count exactly 8 beats).
REQ-037 START_IDX=END_IDX=7 -> single beat Index=7, Done at t+3.
